mem_wb_pipe_reg: RTL and testbench

Parametrised MEM/WB pipeline stage with a valid/ready handshake, 2-entry skid buffering, flush, and writeback-data selection. It replaces the fixed always-enabled MEM/WB register. It sits between the MEM stage and the register-file write port / forwarding unit. A downstream stall therefore back-pressures MEM without dropping or duplicating instructions.

---
 rtl/mem_wb_pipe_reg.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM/WB pipeline stage with a valid/ready handshake and
// two-entry skid buffering.
//
// The stage sits between the MEM stage and the register-file write port and
// forwarding unit. If WB stalls, MEM sees back-pressure through in_ready.
// No instruction is dropped or duplicated, except on flush or reset.
//
// The writeback value is chosen when a beat is captured and is stored in the
// entry, so the outputs are plain register reads. The entry's write enable is
// also qualified at capture time, which means writes to x0 never leave this
// stage.
//
// Optional feature (compile-time macro MEM_WB_PERF_EN):
//   When defined, two saturating performance counters are added and exposed
//   on perf_retire_cnt and perf_stall_cnt. When undefined, those ports and
//   counters do not exist and all other behaviour is the same.
//
// Parameters:
//   XLEN    datapath width (pc, imm, memory data, ALU result, wdata)
//   REG_AW  register-index width
//   CNT_W   performance counter width (used only with MEM_WB_PERF_EN)
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   flush            discard held and incoming beats this cycle
//   in_valid         MEM beat valid
//   in_ready         stage can accept a beat
//   in_we            beat writes the register file
//   in_rd            destination register
//   in_wb_sel        writeback source: 00 ALU, 01 mem, 10 pc+4, 11 imm
//   in_pc            instruction pc
//   in_imm           immediate
//   in_mem_data      load data
//   in_alu_out       ALU result
//   out_valid        WB beat valid
//   out_ready        WB consumer accepts the beat
//   out_we           register-file write enable (qualified by out_valid)
//   out_rd           destination register
//   out_wdata        selected writeback data
//   out_pc           pc of the beat
//   perf_retire_cnt  retires with out_we=1 (MEM_WB_PERF_EN only)
//   perf_stall_cnt   cycles with out_valid=1 and out_ready=0 (MEM_WB_PERF_EN only)

module mem_wb_pipe_reg #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_wb_sel,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_mem_data,
  input  logic [XLEN-1:0]   in_alu_out,

  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_wdata,
  output logic [XLEN-1:0]   out_pc
`ifdef MEM_WB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_retire_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

  // Writeback source encodings
  localparam logic [1:0] WbSelAlu = 2'b00;
  localparam logic [1:0] WbSelMem = 2'b01;
  localparam logic [1:0] WbSelPc4 = 2'b10;
  localparam logic [1:0] WbSelImm = 2'b11;

  // One buffered beat, already reduced to what WB needs.
  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   pc;
  } entry_t;

  // Occupancy encoded as {skid_valid, main_valid}. The skid entry is only
  // ever valid when the main entry is valid, so 2'b10 cannot occur.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StHalf  = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic retire;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  // in_ready comes straight from the skid occupancy flop. It is additionally
  // held low while reset is asserted, so MEM never launches into a stage that
  // is being cleared.
  assign in_ready = ~skid_valid & ~rst;

  assign accept = in_valid & in_ready & ~flush;
  assign retire = main_valid & out_ready;

  // Build the entry for an incoming beat. pc+4 wraps modulo 2^XLEN.
  always_comb begin
    new_entry = '0;
    new_entry.we = in_we & (in_rd != '0);
    new_entry.rd = in_rd;
    new_entry.pc = in_pc;
    unique case (in_wb_sel)
      WbSelAlu: new_entry.wdata = in_alu_out;
      WbSelMem: new_entry.wdata = in_mem_data;
      WbSelPc4: new_entry.wdata = in_pc + XLEN'(4);
      WbSelImm: new_entry.wdata = in_imm;
      default:  new_entry.wdata = in_alu_out;
    endcase
  end

  // Occupancy and data movement. Data fields are only written where a beat
  // is actually captured or shifted. Flush only kills the valid bits, so the
  // data fields may keep stale values.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = StHalf;
        end
      end
      StHalf: begin
        if (accept && retire) begin
          main_d  = new_entry;
        end else if (accept) begin
          // WB is stalled: park the new beat behind the one being held.
          skid_d  = new_entry;
          state_d = StFull;
        end else if (retire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only a retire can change occupancy.
        if (retire) begin
          main_d  = skid_q;
          state_d = StHalf;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase

    // A retire in the flush cycle has already been seen by the consumer.
    // Everything else is discarded.
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Outputs always present the main entry.
  assign out_valid = main_valid;
  assign out_we    = main_valid & main_q.we;
  assign out_rd    = main_q.rd;
  assign out_wdata = main_q.wdata;
  assign out_pc    = main_q.pc;

`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0] perf_retire_q, perf_retire_d;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

  // Both counters saturate at all-ones. Flush does not affect them.
  always_comb begin
    perf_retire_d = perf_retire_q;
    perf_stall_d  = perf_stall_q;
    if (retire && out_we && (perf_retire_q != '1)) begin
      perf_retire_d = perf_retire_q + CNT_W'(1);
    end
    if (main_valid && !out_ready && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retire_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_retire_q <= perf_retire_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_retire_cnt = perf_retire_q;
  assign perf_stall_cnt  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
module tb_mem_wb_pipe_reg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned TB_CNT_W = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_we;
  logic [REG_AW-1:0] in_rd;
  logic [1:0]        in_wb_sel;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_mem_data;
  logic [XLEN-1:0]   in_alu_out;
  logic              out_valid;
  logic              out_ready;
  logic              out_we;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_wdata;
  logic [XLEN-1:0]   out_pc;
`ifdef MEM_WB_PERF_EN
  logic [TB_CNT_W-1:0] perf_retire_cnt;
  logic [TB_CNT_W-1:0] perf_stall_cnt;
`endif

  int n_vec;
  int n_err;

  mem_wb_pipe_reg #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_we       (in_we),
    .in_rd       (in_rd),
    .in_wb_sel   (in_wb_sel),
    .in_pc       (in_pc),
    .in_imm      (in_imm),
    .in_mem_data (in_mem_data),
    .in_alu_out  (in_alu_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_we      (out_we),
    .out_rd      (out_rd),
    .out_wdata   (out_wdata),
    .out_pc      (out_pc)
`ifdef MEM_WB_PERF_EN
    ,
    .perf_retire_cnt (perf_retire_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an ALU-sourced beat on the input.
  task automatic drive_alu(input logic [XLEN-1:0] val, input logic [REG_AW-1:0] rd);
    in_valid   = 1'b1;
    in_we      = 1'b1;
    in_rd      = rd;
    in_wb_sel  = 2'b00;
    in_alu_out = val;
    in_pc      = 32'h0000_1000;
    in_imm     = 32'h5555_5555;
    in_mem_data = 32'hAAAA_AAAA;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_vec++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready); n_err++;
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || out_we !== 1'b0) begin
      $display("FAIL reset_valid_we: got valid=%b we=%b want 0 0", out_valid, out_we); n_err++;
    end
    n_vec++;
    if (out_rd !== 5'd0 || out_wdata !== 32'd0 || out_pc !== 32'd0) begin
      $display("FAIL reset_fields: got rd=%h wdata=%h pc=%h want 0 0 0",
               out_rd, out_wdata, out_pc); n_err++;
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready_after: got %b want 1", in_ready); n_err++;
    end
  endtask

  task automatic test_stream();
    logic [XLEN-1:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'h11 * 32'(i + 1);
      drive_alu(exp, 5'(i + 1));
      n_vec++;
      if (in_ready !== 1'b1) begin
        $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); n_err++;
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_wdata !== exp || out_rd !== 5'(i + 1)) begin
        $display("FAIL stream_out[%0d]: got valid=%b wdata=%h rd=%0d want 1 %h %0d",
                 i, out_valid, out_wdata, out_rd, exp, i + 1); n_err++;
      end
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL stream_drain: got valid=%b want 0", out_valid); n_err++;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_alu(32'h100, 5'd1);
    tick();
    n_vec++;
    if (out_wdata !== 32'h100 || in_ready !== 1'b1) begin
      $display("FAIL bp_first: got wdata=%h in_ready=%b want 100 1", out_wdata, in_ready);
      n_err++;
    end
    drive_alu(32'h200, 5'd2);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_wdata !== 32'h100) begin
      $display("FAIL bp_full: got in_ready=%b valid=%b wdata=%h want 0 1 100",
               in_ready, out_valid, out_wdata); n_err++;
    end
    tick();
    n_vec++;
    if (out_wdata !== 32'h100 || out_rd !== 5'd1 || out_valid !== 1'b1) begin
      $display("FAIL bp_hold: got wdata=%h rd=%0d valid=%b want 100 1 1",
               out_wdata, out_rd, out_valid); n_err++;
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_wdata !== 32'h200 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL bp_second: got wdata=%h valid=%b in_ready=%b want 200 1 1",
               out_wdata, out_valid, in_ready); n_err++;
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_drain: got valid=%b want 0", out_valid); n_err++;
    end
  endtask

  task automatic test_wb_select();
    logic [1:0]      sel_tab  [3];
    logic [XLEN-1:0] exp_tab  [3];
    logic [XLEN-1:0] pc_tab   [3];
    sel_tab[0] = 2'b10; pc_tab[0] = 32'hFFFF_FFFC; exp_tab[0] = 32'h0000_0000;
    sel_tab[1] = 2'b11; pc_tab[1] = 32'h0000_0040; exp_tab[1] = 32'h0000_ABCD;
    sel_tab[2] = 2'b01; pc_tab[2] = 32'h0000_0080; exp_tab[2] = 32'h0000_DEAD;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid    = 1'b1;
      in_we       = 1'b1;
      in_rd       = 5'd9;
      in_wb_sel   = sel_tab[i];
      in_pc       = pc_tab[i];
      in_imm      = 32'h0000_ABCD;
      in_mem_data = 32'h0000_DEAD;
      in_alu_out  = 32'h1234_5678;
      tick();
      n_vec++;
      if (out_wdata !== exp_tab[i] || out_pc !== pc_tab[i]) begin
        $display("FAIL wbsel[%0d]: got wdata=%h pc=%h want %h %h",
                 i, out_wdata, out_pc, exp_tab[i], pc_tab[i]); n_err++;
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    out_ready = 1'b1;
    drive_alu(32'h77, 5'd0);
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_we !== 1'b0) begin
      $display("FAIL x0_suppress: got valid=%b we=%b want 1 0", out_valid, out_we); n_err++;
    end
    drive_alu(32'h78, 5'd5);
    tick();
    n_vec++;
    if (out_we !== 1'b1 || out_rd !== 5'd5) begin
      $display("FAIL x0_rd5: got we=%b rd=%0d want 1 5", out_we, out_rd); n_err++;
    end
    drive_alu(32'h79, 5'd7);
    in_we = 1'b0;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_we !== 1'b0) begin
      $display("FAIL x0_we0: got valid=%b we=%b want 1 0", out_valid, out_we); n_err++;
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (out_we !== 1'b0) begin
      $display("FAIL x0_we_idle: got we=%b want 0", out_we); n_err++;
    end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    drive_alu(32'h500, 5'd3);
    tick();
    drive_alu(32'h600, 5'd4);
    tick();
    n_vec++;
    if (in_ready !== 1'b0) begin
      $display("FAIL flush_pre_full: got in_ready=%b want 0", in_ready); n_err++;
    end
    drive_alu(32'h777, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || out_we !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_after: got valid=%b we=%b in_ready=%b want 0 0 1",
               out_valid, out_we, in_ready); n_err++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
        $display("FAIL flush_ghost[%0d]: got valid=%b wdata=%h want valid 0",
                 i, out_valid, out_wdata); n_err++;
      end
    end
    drive_alu(32'h888, 5'd8);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_wdata !== 32'h888) begin
      $display("FAIL flush_recover: got valid=%b wdata=%h want 1 888", out_valid, out_wdata);
      n_err++;
    end
    tick();
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0;
    drive_alu(32'h901, 5'd1);
    tick();
    drive_alu(32'h902, 5'd2);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_wdata !== 32'd0) begin
      $display("FAIL rst_midstall: got valid=%b in_ready=%b wdata=%h want 0 1 0",
               out_valid, in_ready, out_wdata); n_err++;
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rst_midstall_ghost: got valid=%b want 0", out_valid); n_err++;
    end
  endtask

`ifdef MEM_WB_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    n_vec++;
    if (perf_retire_cnt !== 4'd0 || perf_stall_cnt !== 4'd0) begin
      $display("FAIL perf_reset: got retire=%0d stall=%0d want 0 0",
               perf_retire_cnt, perf_stall_cnt); n_err++;
    end
    drive_alu(32'hA1, 5'd1);
    tick();
    drive_alu(32'hA2, 5'd2);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_vec++;
    if (perf_stall_cnt !== 4'd3 || perf_retire_cnt !== 4'd0) begin
      $display("FAIL perf_stall: got stall=%0d retire=%0d want 3 0",
               perf_stall_cnt, perf_retire_cnt); n_err++;
    end
    out_ready = 1'b1;
    tick();
    tick();
    n_vec++;
    if (perf_retire_cnt !== 4'd2 || perf_stall_cnt !== 4'd3) begin
      $display("FAIL perf_retire: got retire=%0d stall=%0d want 2 3",
               perf_retire_cnt, perf_stall_cnt); n_err++;
    end
    // Thirteen more writing retires bring the 4-bit counter to all-ones.
    for (int i = 0; i < 13; i++) begin
      drive_alu(32'(i), 5'd3);
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (perf_retire_cnt !== 4'hF) begin
      $display("FAIL perf_fill: got retire=%0d want 15", perf_retire_cnt); n_err++;
    end
    drive_alu(32'hB0, 5'd4);
    tick();
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (perf_retire_cnt !== 4'hF || perf_stall_cnt !== 4'd3) begin
      $display("FAIL perf_saturate: got retire=%0d stall=%0d want 15 3",
               perf_retire_cnt, perf_stall_cnt); n_err++;
    end
  endtask
`endif

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_we       = 1'b0;
    in_rd       = '0;
    in_wb_sel   = 2'b00;
    in_pc       = '0;
    in_imm      = '0;
    in_mem_data = '0;
    in_alu_out  = '0;
    out_ready   = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_wb_select();
    test_x0();
    test_flush_full();
    test_reset_midstall();
`ifdef MEM_WB_PERF_EN
    test_perf();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
